// File: rtl/coef_rom_arbiter_pkg.sv
// Shared DDS coefficient-ROM definitions: default widths, ROM output latency
// and the requester-id encoding used by the arbiter and its tag pipeline.
package coef_rom_arbiter_pkg;

  localparam int ADDR_W_DEF  = 11;
  // Matches the coefficient pROM output-register setting.
  localparam int ROM_LAT_DEF = 2;
  localparam int DATA_W_DEF  = 32;

  typedef enum logic {
    REQ_ID_0 = 1'b0,
    REQ_ID_1 = 1'b1
  } req_id_e;

  function automatic req_id_e other_id(input req_id_e id);
    return (id == REQ_ID_0) ? REQ_ID_1 : REQ_ID_0;
  endfunction

endpackage

// File: rtl/coef_tag_pipe.sv
// Valid/requester-id shift register tracking reads in flight through the
// coefficient ROM; a synchronous clear drops every outstanding read.
module coef_tag_pipe
  import coef_rom_arbiter_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  req_id_e          id_i,
  output logic [DEPTH-1:0] vld_o,
  output req_id_e          id_o
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] id_q;

  // NOTE: every register here is reset because a stale valid bit after reset
  // would emit a phantom result; the id bits are reset only for determinism.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage shift from the
      // pre-edge value of its neighbour, independent of statement order.
      vld_q <= clr_i ? '0 : {vld_q[DEPTH-2:0], push_i};
      id_q  <= {id_q[DEPTH-2:0], id_i};
    end
  end

  assign vld_o = vld_q;
  assign id_o  = req_id_e'(id_q[DEPTH-1]);

endmodule

// File: rtl/coef_rom_arbiter.sv
// Two-requester round-robin arbiter in front of a pipelined coefficient ROM;
// returns sin/cos words to the granted requester in grant order.
module coef_rom_arbiter
  import coef_rom_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              clr,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_sin,
  input  logic [DATA_W-1:0] rom_cos,
  output logic              vld0,
  output logic              vld1,
  output logic [DATA_W-1:0] sin_out,
  output logic [DATA_W-1:0] cos_out,
  output logic              busy
);

  localparam int DEPTH = ROM_LAT + 1;

  req_id_e           ptr_q, ptr_d;
  req_id_e           gnt_id;
  logic              gnt_any;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [DATA_W-1:0] sin_q, cos_q;
  logic [DEPTH-1:0]  tag_vld;
  req_id_e           tag_id;

  // Grants are suppressed during reset and flush so nothing enters the pipe.
  always_comb begin
    // NOTE: defaults first so every path assigns both grants (no latch).
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (RESETn && !clr) begin
      if (req0 && req1) begin
        gnt0 = (ptr_q == REQ_ID_0);
        gnt1 = (ptr_q == REQ_ID_1);
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign gnt_any = gnt0 | gnt1;
  assign gnt_id  = gnt1 ? REQ_ID_1 : REQ_ID_0;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = other_id(gnt_id);
  end

  // The capture stage is one ahead of the strobe stage, so data and vld align.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      ptr_q      <= REQ_ID_0;
      rom_addr_q <= '0;
      sin_q      <= '0;
      cos_q      <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (gnt_any) rom_addr_q <= gnt1 ? addr1 : addr0;
      if (tag_vld[DEPTH-2] && !clr) begin
        sin_q <= rom_sin;
        cos_q <= rom_cos;
      end
    end
  end

  coef_tag_pipe #(
    .DEPTH (DEPTH)
  ) u_tag_pipe (
    .clk    (Fg_CLK),
    .rst_n  (RESETn),
    .clr_i  (clr),
    .push_i (gnt_any),
    .id_i   (gnt_id),
    .vld_o  (tag_vld),
    .id_o   (tag_id)
  );

  assign rom_addr = rom_addr_q;
  assign sin_out  = sin_q;
  assign cos_out  = cos_q;
  assign vld0     = tag_vld[DEPTH-1] && (tag_id == REQ_ID_0);
  assign vld1     = tag_vld[DEPTH-1] && (tag_id == REQ_ID_1);
  assign busy     = |tag_vld;

endmodule
